icache_dm: RTL and testbench

- Direct-mapped, read-only instruction cache between the cpu instruction-fetch port (im_addr/im_valid/im_data) and a slower backing instruction memory.
- Hits return the instruction combinationally in the same cycle.
- Misses stall the fetch stage (im_valid=0) while a single-outstanding-request FSM refills the whole line, then the access hits.

---
 rtl/icache_dm.sv | 157 +++++++++++++++
 tb/tb_icache_dm.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_dm.sv
// icache_dm: direct-mapped, read-only instruction cache.
// Hits return the word combinationally in the same cycle. A miss stalls
// the fetch stage while a two-state fill FSM streams the whole line from
// the backing memory, always word 0 upward, one request outstanding.
// Optional hit/miss statistics are built only when ICACHE_STATS_EN is
// defined. Otherwise hit_count and miss_count are tied to zero and the
// port list stays the same.
//
// state | meaning
// IDLE  | lookups active; a non-hit cycle without inv starts a line fill
// FILL  | mem_req high; each ack writes one word; the last ack closes the line

module icache_dm #(
    parameter int LINES          = 16,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] im_addr,
    output logic        im_valid,
    output logic [31:0] im_data,
    input  logic        inv,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);

    localparam int OFF_W = $clog2(WORDS_PER_LINE);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = 30 - OFF_W - IDX_W;

    typedef enum logic {
        IDLE,
        FILL
    } state_t;

    state_t state;

    logic [TAG_W-1:0] tag_arr  [LINES];
    logic [31:0]      data_arr [LINES][WORDS_PER_LINE];
    logic [LINES-1:0] valid;

    logic [TAG_W-1:0] fill_tag;
    logic [IDX_W-1:0] fill_idx;
    logic [OFF_W-1:0] cnt;
    logic             inv_pend;

    logic [OFF_W-1:0] offset;
    logic [IDX_W-1:0] index;
    logic [TAG_W-1:0] tag;
    logic             hit;
    logic             last_word;
    logic             unused_addr_bits;

    // Fetch address split; the byte-within-word bits carry no meaning.
    assign offset           = im_addr[OFF_W+1:2];
    assign index            = im_addr[OFF_W+IDX_W+1:OFF_W+2];
    assign tag              = im_addr[31:OFF_W+IDX_W+2];
    assign unused_addr_bits = ^im_addr[1:0];

    // Lookup is only honoured in IDLE, so the cpu stays stalled for the whole fill.
    assign hit      = (state == IDLE) && valid[index] && (tag_arr[index] == tag);
    assign im_valid = hit;
    assign im_data  = data_arr[index][offset];

    // Request is decoded straight from the state so it drops with async reset.
    assign mem_req   = (state == FILL);
    assign mem_addr  = {fill_tag, fill_idx, cnt, 2'b00};
    assign last_word = (cnt == OFF_W'(WORDS_PER_LINE - 1));

    // Fill FSM: line latch, word counter, valid bits and the sticky invalidate.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            fill_tag <= '0;
            fill_idx <= '0;
            cnt      <= '0;
            inv_pend <= 1'b0;
            valid    <= '0;
        end else begin
            // Invalidate drops every line, including any line already complete.
            if (inv) begin
                valid <= '0;
            end
            case (state)
                IDLE: begin
                    if (!hit && !inv) begin
                        fill_tag <= tag;
                        fill_idx <= index;
                        cnt      <= '0;
                        state    <= FILL;
                    end
                end
                FILL: begin
                    // An invalidate seen during the fill must keep this line invalid.
                    if (inv) begin
                        inv_pend <= 1'b1;
                    end
                    if (mem_ack) begin
                        cnt <= cnt + 1'b1;
                        if (last_word) begin
                            if (!inv_pend && !inv) begin
                                valid[fill_idx] <= 1'b1;
                            end
                            inv_pend <= 1'b0;
                            state    <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Tag and data storage. Only the fill path writes it, and it needs no reset because valid gates every use.
    always_ff @(posedge clk) begin
        if (state == FILL && mem_ack) begin
            data_arr[fill_idx][cnt] <= mem_rdata;
            if (last_word) begin
                tag_arr[fill_idx] <= fill_tag;
            end
        end
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_q;
    logic [31:0] miss_q;

    // Wrapping statistics. An invalidate wins over any increment in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_q  <= '0;
            miss_q <= '0;
        end else if (inv) begin
            hit_q  <= '0;
            miss_q <= '0;
        end else begin
            if (hit) begin
                hit_q <= hit_q + 32'd1;
            end
            if (state == IDLE && !hit) begin
                miss_q <= miss_q + 32'd1;
            end
        end
    end

    assign hit_count  = hit_q;
    assign miss_count = miss_q;
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

endmodule

// File: tb/tb_icache_dm.sv
// Self-checking bench for icache_dm using the default geometry (16 lines, 4 words).
// The backing memory returns a fixed function of the address. It can answer
// with zero wait states or acknowledge every third request cycle.
// A line-level model of the cache predicts hits, misses, fill addresses,
// miss latency and the statistics counters.

module tb_icache_dm;

    localparam int LINES = 16;
    localparam int WPL   = 4;

`ifdef ICACHE_STATS_EN
    localparam logic [31:0] STATS_MASK = 32'hFFFF_FFFF;
`else
    localparam logic [31:0] STATS_MASK = 32'h0;
`endif

    logic        clk;
    logic        rst;
    logic [31:0] im_addr;
    logic        im_valid;
    logic [31:0] im_data;
    logic        inv;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    int n_cmp = 0;
    int n_err = 0;

    bit          wait_mode;
    logic [1:0]  gap_cnt;

    bit          mv    [LINES];
    logic [27:0] mline [LINES];
    int          exp_hits;
    int          exp_misses;

    icache_dm #(.LINES(LINES), .WORDS_PER_LINE(WPL)) dut (
        .clk        (clk),
        .rst        (rst),
        .im_addr    (im_addr),
        .im_valid   (im_valid),
        .im_data    (im_data),
        .inv        (inv),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return {a[31:4] ^ 28'h10, 4'h0} + 32'hA0 + {30'b0, a[3:2]};
    endfunction

    // Backing memory: combinational data, ack either immediate or on every third request cycle.
    assign mem_rdata = mem_fn(mem_addr);
    assign mem_ack   = mem_req && (wait_mode ? (gap_cnt == 2'd2) : 1'b1);

    always @(posedge clk or posedge rst) begin
        if (rst)           gap_cnt <= 2'd0;
        else if (mem_ack)  gap_cnt <= 2'd0;
        else if (mem_req)  gap_cnt <= gap_cnt + 2'd1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int line_idx(input logic [31:0] a);
        return int'((a >> 4) % LINES);
    endfunction

    function automatic bit model_hit(input logic [31:0] a);
        return mv[line_idx(a)] && (mline[line_idx(a)] == a[31:4]);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < LINES; i++) mv[i] = 1'b0;
        exp_hits   = 0;
        exp_misses = 0;
    endtask

    // One fetch. It is entered just after a rising edge and returns just after the edge that ends the hit cycle.
    task automatic access(input logic [31:0] a, input logic exp_v, input logic [31:0] exp_d, input string nm);
        int          lat;
        int          nack;
        logic [31:0] base;
        im_addr = a;
        @(negedge clk);
        chk({nm, " first valid"}, {31'b0, im_valid}, {31'b0, exp_v});
        if (!im_valid) begin
            exp_misses++;
            base = a & ~32'(WPL * 4 - 1);
            lat  = 0;
            nack = 0;
            while (!im_valid && lat < 200) begin
                @(negedge clk);
                lat++;
                if (!im_valid) begin
                    chk({nm, " mem_req"}, {31'b0, mem_req}, 32'd1);
                    chk({nm, " mem_addr"}, mem_addr, base + 32'(4 * nack));
                    if (mem_ack) nack++;
                end
            end
            chk({nm, " latency"}, 32'(lat), 32'(WPL * (wait_mode ? 3 : 1) + 1));
            mv[line_idx(a)]    = 1'b1;
            mline[line_idx(a)] = a[31:4];
        end
        chk({nm, " valid"}, {31'b0, im_valid}, 32'd1);
        chk({nm, " data"}, im_data, exp_d);
        chk({nm, " idle req"}, {31'b0, mem_req}, 32'd0);
        chk({nm, " hit_count"}, hit_count, 32'(exp_hits) & STATS_MASK);
        chk({nm, " miss_count"}, miss_count, 32'(exp_misses) & STATS_MASK);
        exp_hits++;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_inv_idle(input logic [31:0] a);
        im_addr = a;
        inv     = 1'b1;
        @(posedge clk);
        #1;
        inv = 1'b0;
        model_clear();
    endtask

    typedef struct {
        logic [31:0] addr;
        bit          wm;
        logic        exp_v;
        logic [31:0] exp_d;
    } vec_t;

    vec_t vecs [8];

    initial begin
        logic [31:0] ra;
        vecs[0] = '{32'h100, 1'b0, 1'b0, 32'hA0};   // conflicts with line 0x0 at index 0
        vecs[1] = '{32'h108, 1'b0, 1'b1, 32'hA2};
        vecs[2] = '{32'h200, 1'b0, 1'b0, 32'h3A0};  // index 0, tag 2
        vecs[3] = '{32'h100, 1'b0, 1'b0, 32'hA0};   // evicted, refetched
        vecs[4] = '{32'h10E, 1'b0, 1'b1, 32'hA3};   // byte bits ignored
        vecs[5] = '{32'h340, 1'b1, 1'b0, 32'h2E0};  // wait states
        vecs[6] = '{32'h348, 1'b0, 1'b1, 32'h2E2};
        vecs[7] = '{32'h000, 1'b0, 1'b0, 32'h1A0};

        rst       = 1'b1;
        inv       = 1'b0;
        im_addr   = 32'h0;
        wait_mode = 1'b0;
        for (int i = 0; i < LINES; i++) mline[i] = '0;
        model_clear();

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset im_valid", {31'b0, im_valid}, 32'd0);
        chk("reset mem_req", {31'b0, mem_req}, 32'd0);
        chk("reset mem_addr", mem_addr, 32'd0);
        chk("reset hit_count", hit_count, 32'd0);
        chk("reset miss_count", miss_count, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        access(32'h0, 1'b0, 32'h1A0, "t1 first fill");

        // Table: cold miss, conflict, wait states
        for (int i = 0; i < 8; i++) begin
            wait_mode = vecs[i].wm;
            access(vecs[i].addr, vecs[i].exp_v, vecs[i].exp_d, $sformatf("vec%0d", i));
        end
        wait_mode = 1'b0;

        // Invalidate during the second word of a fill at 0x100
        im_addr = 32'h100;
        @(negedge clk);
        chk("t5 miss", {31'b0, im_valid}, 32'd0);
        exp_misses++;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        inv = 1'b1;
        @(negedge clk);
        chk("t5 word1 addr", mem_addr, 32'h104);
        @(posedge clk);
        #1;
        inv = 1'b0;
        model_clear();
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("t5 word3 addr", mem_addr, 32'h10C);
        chk("t5 word3 req", {31'b0, mem_req}, 32'd1);
        @(posedge clk);
        #1;
        access(32'h100, 1'b0, 32'hA0, "t5 refill");

        // Invalidate in IDLE drops a valid line
        pulse_inv_idle(32'h100);
        access(32'h100, 1'b0, 32'hA0, "inv idle refill");
        access(32'h104, 1'b1, 32'hA1, "inv idle hit");

        // Async reset mid-fill at word 2
        pulse_inv_idle(32'h100);
        im_addr = 32'h100;
        @(negedge clk);
        chk("t6 miss", {31'b0, im_valid}, 32'd0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        #2;
        rst = 1'b1;
        #1;
        chk("t6 req drops", {31'b0, mem_req}, 32'd0);
        @(negedge clk);
        chk("t6 hit_count", hit_count, 32'd0);
        chk("t6 miss_count", miss_count, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
        access(32'h100, 1'b0, 32'hA0, "t6 restart");

        // Random fetches against the line model
        for (int n = 0; n < 400; n++) begin
            ra        = ($urandom & 32'h0000_0FFF) | (($urandom % 4 == 0) ? 32'h8000_0000 : 32'h0);
            wait_mode = bit'($urandom % 2);
            if ($urandom % 16 == 0) pulse_inv_idle(ra);
            access(ra, model_hit(ra), mem_fn(ra), $sformatf("rnd%0d", n));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
